// File: rtl/stream_data_emitter.sv
// Outbound packet serialiser: round-robin grants one core at a time, emits a
// header word followed by the core's payload. Optional: STREAM_EMITTER_TIMEOUT_EN.
module stream_data_emitter #(
    parameter int CORES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CORES-1:0]     core_req,
    input  logic [CORES*32-1:0]  core_length,
    input  logic [CORES*32-1:0]  core_data_id,
    input  logic [CORES*512-1:0] core_data,
    input  logic [CORES-1:0]     core_valid,
    output logic [CORES-1:0]     core_ready,
    output logic [CORES-1:0]     core_grant,
    output logic [CORES-1:0]     core_done,
    output logic [511:0]         src_data,
    output logic                 src_valid,
    input  logic                 src_ready,
    output logic                 src_sop,
    output logic                 src_eop,
`ifdef STREAM_EMITTER_TIMEOUT_EN
    output logic                 timeout_err,
`endif
    output logic                 busy
);

    localparam int IDXW = $clog2(CORES);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

    state_t          state, state_nxt;
    logic [IDXW-1:0] last_grant, grant_idx, pick_idx;
    logic            pick_vld;
    logic [31:0]     remaining;
    logic [31:0]     pick_len, pick_id;
    logic [511:0]    g_data;
    logic            g_valid;
    logic            slot_free, src_fire, accept, pad, pad_load;

    // Round-robin search starting one past the last granted core.
    always_comb begin
        int k;
        pick_vld = 1'b0;
        pick_idx = last_grant;
        k        = 0;
        for (int i = 1; i <= CORES; i++) begin
            k = (int'(last_grant) + i) % CORES;
            if (!pick_vld && core_req[IDXW'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'(k);
            end
        end
    end

    assign pick_len  = core_length[pick_idx*32 +: 32];
    assign pick_id   = core_data_id[pick_idx*32 +: 32];
    assign g_data    = core_data[grant_idx*512 +: 512];
    assign g_valid   = core_valid[grant_idx];
    assign slot_free = !src_valid || src_ready;
    assign src_fire  = src_valid && src_ready;
    assign accept    = core_ready[grant_idx] && g_valid;
    assign pad_load  = pad && (state == PAYLOAD) && slot_free && (remaining != 32'd0);
    assign busy      = (state != IDLE);
    assign core_done = (state == DONE) ? core_grant : '0;

    // Ready never looks at core_valid, so cores may wait on it safely.
    always_comb begin
        core_ready = '0;
        if (state == PAYLOAD && slot_free && remaining != 32'd0 && !pad)
            core_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = HEADER;
            HEADER:  if (src_fire) state_nxt = (remaining == 32'd0) ? DONE : PAYLOAD;
            PAYLOAD: if (src_fire && src_eop) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDXW'(CORES - 1);
            grant_idx  <= '0;
            core_grant <= '0;
            remaining  <= '0;
            src_data   <= '0;
            src_valid  <= 1'b0;
            src_sop    <= 1'b0;
            src_eop    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (pick_vld) begin
                    grant_idx  <= pick_idx;
                    last_grant <= pick_idx;
                    core_grant <= CORES'(1) << pick_idx;
                    remaining  <= pick_len;
                    src_data   <= {448'b0, pick_id, pick_len + 32'd1};
                    src_valid  <= 1'b1;
                    src_sop    <= 1'b1;
                    src_eop    <= (pick_len == 32'd0);
                end
                HEADER: if (src_fire) begin
                    src_valid <= 1'b0;
                    src_sop   <= 1'b0;
                    src_eop   <= 1'b0;
                end
                PAYLOAD: begin
                    if (accept || pad_load) begin
                        src_data  <= pad ? 512'b0 : g_data;
                        src_valid <= 1'b1;
                        src_eop   <= (remaining == 32'd1);
                        remaining <= remaining - 32'd1;
                    end else if (src_fire) begin
                        src_valid <= 1'b0;
                    end
                end
                DONE: begin
                    core_grant <= '0;
                    src_eop    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef STREAM_EMITTER_TIMEOUT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt   <= '0;
            pad         <= 1'b0;
            timeout_err <= 1'b0;
        end else if (state == PAYLOAD) begin
            if (accept)
                stall_cnt <= '0;
            else if (core_ready[grant_idx] && !g_valid && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (stall_cnt == 16'hFFFF)
                pad <= 1'b1;
        end else if (state == DONE) begin
            if (pad) timeout_err <= 1'b1;
            pad       <= 1'b0;
            stall_cnt <= '0;
        end
    end
`else
    assign pad = 1'b0;
`endif

endmodule

// File: tb/tb_stream_data_emitter.sv
// Scoreboard bench for stream_data_emitter: core models feed payload, expected
// outbound words are queued on grant/accept and compared at the stream output.
module tb_stream_data_emitter;
    localparam int CORES = 4;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic [CORES-1:0]     core_req = '0, core_valid = '0;
    logic [CORES-1:0]     core_ready, core_grant, core_done;
    logic [CORES*32-1:0]  core_length = '0, core_data_id = '0;
    logic [CORES*512-1:0] core_data = '0;
    logic [511:0]         src_data;
    logic                 src_valid, src_sop, src_eop, busy;
    logic                 src_ready = 1'b1;

    stream_data_emitter #(.CORES(CORES)) dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_length(core_length),
        .core_data_id(core_data_id), .core_data(core_data), .core_valid(core_valid),
        .core_ready(core_ready), .core_grant(core_grant), .core_done(core_done),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sop(src_sop), .src_eop(src_eop), .busy(busy)
    );

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed { logic [511:0] d; logic sop; logic eop; } word_t;

    word_t sb[$];
    int    exp_g[$];
    int    len[CORES], idv[CORES], pend[CORES], sent[CORES], pkt[CORES];
    int    cur = -1, vprob = 100, rmode = 0, cyc = 0;
    logic [CORES-1:0] prev_grant = '0, done_exp = '0;
    word_t hold_w;
    bit    hold_chk = 0;

    function automatic logic [511:0] pay(input int c, input int p, input int i);
        logic [7:0] c8, p8; logic [15:0] i16;
        c8 = c[7:0]; p8 = p[7:0]; i16 = i[15:0];
        return {16{c8, p8, i16}};
    endfunction

    // Core models + output monitor: drive at negedge, evaluate handshakes just after.
    always @(negedge clk) begin
        cyc++;
        case (rmode)
            0:       src_ready = 1'b1;
            1:       src_ready = (cyc % 3 == 0);
            default: src_ready = 1'($urandom_range(0, 1));
        endcase
        for (int c = 0; c < CORES; c++) begin
            core_req[c] = (pend[c] > 0);
            if (core_grant[c] && sent[c] < len[c]) begin
                core_valid[c] = ($urandom_range(0, 99) < vprob);
                core_data[c*512 +: 512] = pay(c, pkt[c], sent[c]);
            end else begin
                core_valid[c] = 1'($urandom_range(0, 1));
                core_data[c*512 +: 512] = {16{$urandom}};
            end
            core_length[c*32 +: 32]  = core_grant[c] ? 32'h0000_0BAD : 32'(len[c]);
            core_data_id[c*32 +: 32] = core_grant[c] ? 32'hBAD0_0000 : 32'(idv[c]);
        end
        #1;
        if (reset) begin
            prev_grant = '0;
            hold_chk   = 0;
        end else begin
            chk("ready_mask", core_ready & ~core_grant, '0);
            if (cur >= 0 && sent[cur] >= len[cur] && core_ready != '0)
                chk("ready_after_last", core_ready, '0);
            if (hold_chk)
                chk("hold", {src_valid, src_data, src_sop, src_eop}, {1'b1, hold_w});
            if (core_done != '0 || done_exp != '0) begin
                chk("done", core_done, done_exp);
                for (int c = 0; c < CORES; c++)
                    if (done_exp[c]) begin
                        pend[c]--; sent[c] = 0; pkt[c]++; cur = -1;
                    end
                done_exp = '0;
            end
            if (core_grant != '0 && prev_grant == '0) begin
                if (exp_g.size() == 0) chk("grant_unexp", core_grant, '0);
                else begin
                    int g;
                    g = exp_g.pop_front();
                    chk("grant", core_grant, CORES'(1) << g);
                    cur = g;
                    sb.push_back({448'b0, 32'(idv[g]), 32'(len[g] + 1), 1'b1, len[g] == 0});
                end
            end
            prev_grant = core_grant;
            if (src_valid && src_ready) begin
                if (sb.size() == 0) chk("extra_word", {src_data, src_sop, src_eop}, '0);
                else chk("word", {src_data, src_sop, src_eop}, sb.pop_front());
                if (src_eop && cur >= 0) done_exp = CORES'(1) << cur;
            end
            hold_chk = src_valid && !src_ready;
            hold_w   = {src_data, src_sop, src_eop};
            for (int c = 0; c < CORES; c++)
                if (core_valid[c] && core_ready[c]) begin
                    if (c != cur || sent[c] >= len[c]) chk("bad_accept", c, cur);
                    else begin
                        sb.push_back({pay(c, pkt[c], sent[c]), 1'b0, sent[c] == len[c] - 1});
                        sent[c]++;
                    end
                end
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        bit idle = 0;
        while (!idle && n < 3000) begin
            @(negedge clk); #2; n++;
            idle = !busy && sb.size() == 0 && exp_g.size() == 0;
            for (int c = 0; c < CORES; c++) if (pend[c] != 0) idle = 0;
        end
        chk({tag, "_complete"}, idle, 1'b1);
    endtask

    task automatic clear_model();
        for (int c = 0; c < CORES; c++) begin
            pend[c] = 0; sent[c] = 0; len[c] = 0; idv[c] = 0;
        end
        sb.delete(); exp_g.delete(); cur = -1; done_exp = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        for (int c = 0; c < CORES; c++) pkt[c] = 0;
        repeat (3) @(negedge clk);
        #2 chk("reset_out", {src_valid, src_sop, src_eop, busy, core_grant, core_ready, core_done, src_data}, '0);
        @(negedge clk) reset = 1'b0;

        // single packet, L=3
        len[1] = 3; idv[1] = 32'h55; pend[1] = 1; exp_g.push_back(1);
        wait_idle("basic");

        // header-only packet
        len[0] = 0; idv[0] = 7; pend[0] = 1; exp_g.push_back(0);
        wait_idle("len0");

        // fairness from reset, all cores requesting twice
        @(negedge clk) reset = 1'b1;
        for (int c = 0; c < CORES; c++) begin len[c] = 1; idv[c] = 32'h100 + c; pend[c] = 2; end
        for (int r = 0; r < 2; r++) for (int c = 0; c < CORES; c++) exp_g.push_back(c);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_idle("fair");

        // downstream backpressure 1,0,0 pattern
        rmode = 1; len[2] = 4; idv[2] = 32'hA2; pend[2] = 1; exp_g.push_back(2);
        wait_idle("stall");

        // random backpressure and core gaps, two competing cores
        rmode = 2; vprob = 60;
        len[0] = 6; idv[0] = 32'hC0; pend[0] = 1;
        len[3] = 2; idv[3] = 32'hC3; pend[3] = 1;
        exp_g.push_back(3); exp_g.push_back(0);
        wait_idle("random");

        // reset in the middle of a packet
        rmode = 0; vprob = 100;
        len[2] = 5; idv[2] = 32'hE2; pend[2] = 1; exp_g.push_back(2);
        begin
            int n = 0;
            while (sent[2] < 2 && n < 200) begin @(negedge clk); #2; n++; end
            chk("mid_reached", sent[2] >= 2, 1'b1);
        end
        @(negedge clk) reset = 1'b1;
        @(negedge clk); #2;
        chk("mid_reset", {src_valid, busy, core_grant, core_ready}, '0);
        clear_model();
        @(negedge clk) reset = 1'b0;
        len[1] = 2; idv[1] = 32'h99; pend[1] = 1; exp_g.push_back(1);
        wait_idle("after_reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/stream_data_emitter.md
Name: stream_data_emitter

Overview:
- Return-direction counterpart of the inbound stream parser.
- Collects finished result packets from the compute cores and serialises them onto one 512-bit outbound stream.
- Each packet starts with a header word: [31:0] = total word count including the header, [63:32] = data_id. This is the same framing the inbound side consumes.
- Round-robin arbitration between cores; one packet in flight at a time.

Parameters:
- CORES, 4, number of compute cores; ≥2. Core index width is $clog2(CORES).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core_req  in  CORES  core i has a complete result packet pending
- core_length  in  CORES*32  payload word count of core i, in slice [32*i+:32]; excludes the header
- core_data_id  in  CORES*32  data_id of core i's packet
- core_data  in  CORES*512  payload word of core i
- core_valid  in  CORES  payload word valid, core i
- core_ready  out  CORES  payload word accepted, core i; only the granted bit may be 1
- core_grant  out  CORES  one-hot; held for the whole packet
- core_done  out  CORES  one-cycle pulse when core i's packet is fully emitted
- src_data  out  512  outbound stream word
- src_valid  out  1  outbound word valid
- src_ready  in  1  downstream accepts
- src_sop  out  1  first word (header) of packet
- src_eop  out  1  last word of packet
- busy  out  1  packet in progress (state != IDLE)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer last_grant = CORES-1; remaining = 0.
- Outbound register: src_data, src_valid, src_sop and src_eop are registered and held stable while src_valid && !src_ready.
- IDLE
  - If any core_req is set, grant the first requesting core searching from last_grant+1 (mod CORES).
  - Latch its length L and its id.
  - Load header: src_data = {448'b0, id, L+1}, where L+1 is computed in 32 bits and wraps to 0 if L = 0xFFFFFFFF (not checked).
  - Set src_valid=1, src_sop=1, src_eop=(L==0). Set core_grant, update last_grant, remaining=L. Go to HEADER.
  - Decision to src_valid takes 1 cycle.
- HEADER: on src_valid && src_ready, clear sop/valid. If remaining==0, go to DONE; else go to PAYLOAD.
- PAYLOAD
  - core_ready[g] = (!src_valid || src_ready) && remaining != 0, combinational from state and registers only. It never depends on core_valid.
  - On core_valid[g] && core_ready[g]: src_data = core_data[g], src_valid=1, src_eop=(remaining==1), remaining decrements.
  - If a word is accepted downstream with no new word loaded, src_valid goes to 0.
  - When the eop word is accepted downstream, go to DONE.
  - Full throughput: one word per cycle while src_ready stays high.
- DONE (1 cycle): pulse core_done[g], clear core_grant, go to IDLE.
  - The core must drop core_req in the cycle after core_done. core_req seen in DONE is ignored.
- Non-granted cores: their core_valid is ignored and core_ready stays 0.
- Requests during a packet: new core_req assertions are only sampled in IDLE, so a minimum 1 idle cycle separates packets.
- Fairness: all cores requesting continuously are granted in order g, g+1, …, wrapping.
- core_length/core_data_id are sampled only in IDLE at grant; later changes have no effect.
- Reset mid-packet: returns to IDLE immediately. src_valid, grant and ready drop the next cycle; the partial packet is abandoned with no eop.

Optional Feature:
- STREAM_EMITTER_TIMEOUT_EN.
- Defined: a 16-bit stall counter runs in PAYLOAD.
  - It resets on every accepted core word and counts cycles with core_ready[g]=1 && core_valid[g]=0.
  - At 0xFFFF the emitter pads the remaining words with 512'b0 at one per downstream slot; eop stays correct.
  - It then goes to DONE and raises sticky output timeout_err, cleared only by reset.
- Undefined: no counter and no timeout_err port; the emitter waits indefinitely.

Test Plan:
- Core 1 req, L=3, id=0x55, src_ready=1 → header 0x…_00000055_00000004 with sop; 3 payload words; eop on the 3rd; core_done[1] pulses 1 cycle after eop.
- L=0, id=7 → single word {id=7, len=1} with sop=1 and eop=1 together; no core_ready asserted.
- All 4 cores req simultaneously from reset, L=1 each → grant order 0,1,2,3, then 0 if still requesting.
- L=4, src_ready toggled 1,0,0,1,… → src_data held stable while stalled; no word dropped or duplicated; payload order preserved.
- Reset asserted on the 2nd payload word of L=5 → next cycle: src_valid=0, core_grant=0, busy=0; a new request is then serviced normally.
- (STREAM_EMITTER_TIMEOUT_EN) L=4, core sends 1 word then goes idle → after 65535 stall cycles, 3 zero words are emitted, eop on the last, timeout_err=1.
